ring_osc_scan_ctrl: RTL and testbench
=====================================

# ring_osc_scan_ctrl

Measurement sequencer for the ring-oscillator array. It selects each oscillator in turn and clears the shared ring counter. It then opens a gate window of a fixed number of `clk` cycles, closes the gate, waits for the count to settle, and captures the count. Each result is streamed out over a valid/ready port, and the block tracks the fastest oscillator of the scan. It sits between the host/register interface and the counting datapath.

## Interface
- `NUM_RO`, default 8: number of oscillators scanned; range 2..256.
- `GATE_CYCLES`, default 100: gate window length in `clk` cycles; must be ≥1.
- `SETTLE_CYCLES`, default 4: wait after gate close before sampling `cnt_in`; must be ≥2, which covers the counter clock-domain crossing.
- `CNT_W`, default 8: width of the ring count.
- `SEL_W`, derived: `$clog2(NUM_RO)`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request one full scan; sampled only in IDLE.
- `abort` in 1: terminate the scan and return to IDLE.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse at the end of a completed scan.
- `ro_sel` out SEL_W: oscillator mux select.
- `ro_en` out 1: gate enable to the oscillator/counter.
- `cnt_clr` out 1: one-cycle clear to the ring counter.
- `cnt_in` in CNT_W: ring counter value.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_idx` out SEL_W, `res_value` out CNT_W: result payload.
- `max_idx` out SEL_W, `max_value` out CNT_W: fastest oscillator of the last scan.

## Operation
- FSM states: IDLE → CLEAR → GATE → SETTLE → CAPTURE → EMIT → (CLEAR | DONE) → IDLE.
- **IDLE:** `start`=1 loads idx=0, clears `max_value`/`max_idx` to 0, and goes to CLEAR.
- **CLEAR:** `cnt_clr`=1 for exactly one cycle. `ro_sel`=idx, held stable from CLEAR through EMIT.
- **GATE:** `ro_en`=1 for exactly GATE_CYCLES cycles.
- **SETTLE:** `ro_en`=0 for SETTLE_CYCLES cycles.
- **CAPTURE:** latch `cnt_in` into `res_value` and idx into `res_idx`.
  - If `cnt_in` > `max_value` (strictly greater), update `max_value`/`max_idx`.
  - Ties keep the lower index.
- **EMIT:** `res_valid`=1 with the payload held stable until `res_ready`.
  - On handshake: if idx==NUM_RO-1, go to DONE; otherwise idx+1 and go to CLEAR.
  - The gate never reopens until the previous result is accepted (backpressure stalls the scan).
- **DONE:** `done`=1 for one cycle, then IDLE. `max_*` hold until the next `start`.
- **Boundaries:**
  - `start` while busy is ignored.
  - `abort` has priority over every transition except `rst`. The next state is IDLE, with `ro_en`, `cnt_clr`, `res_valid` and `done` low from the following cycle. `max_*` are left at partial values, and no `done` pulse is produced.
  - `start`=`abort`=1 in IDLE: stay in IDLE.
  - Count wrap in the counter is not detected; CNT_W/GATE_CYCLES are sized by the integrator.
- **Reset values:** state IDLE; all outputs 0 (`busy`, `done`, `ro_sel`, `ro_en`, `cnt_clr`, `res_valid`, `res_idx`, `res_value`, `max_idx`, `max_value`).

## Timing
- All outputs are registered (Moore); no combinational path from inputs to outputs.
- `start` is sampled in cycle 0; CLEAR occurs in cycle 1.
- With `res_ready` tied high, each oscillator takes GATE_CYCLES+SETTLE_CYCLES+3 cycles.
- `done` is asserted in cycle NUM_RO·(GATE_CYCLES+SETTLE_CYCLES+3)+1; `busy` falls the cycle after.
- Each stalled `res_ready` cycle adds exactly one cycle.
- `rst` takes effect at the next `clk` edge and overrides `abort`/`start`.

## Structure
- Shared package `ring_osc_pkg`: the FSM state enum, plus reusable constant definitions for the timer width derivation, `$clog2(max(GATE_CYCLES,SETTLE_CYCLES))`.
- Sub-module `ring_osc_timer`: a loadable down-counter with a `load`/`expired` interface, used for both the GATE and SETTLE windows.
- Top level contains the FSM, index register, result/max registers and handshake.

## Test plan
All scenarios use NUM_RO=4, GATE_CYCLES=10, SETTLE_CYCLES=2.
- **Nominal scan:** `cnt_in` model returns 40,55,30,55 and `res_ready`=1. Required:
  - results (0,40),(1,55),(2,30),(3,55) with each `res_valid` lasting one cycle;
  - `done` in cycle 61;
  - `max_idx`=1, `max_value`=55 (tie keeps idx 1).
- **Backpressure:** `res_ready` low for 5 cycles on idx 2 → payload stable throughout, `ro_en` stays 0 during the stall, `done` in cycle 66.
- **Window check:** count `ro_en` high cycles per oscillator → exactly 10. Count `cnt_clr` pulses per scan → exactly 4, each 1 cycle, with `ro_sel` matching idx.
- **Abort mid-GATE** on idx 1 (cycle 20) → `ro_en`=0 in cycle 21, `busy`=0 in cycle 21, no `done`, no further `res_valid`. A new `start` then rescans from idx 0 with `max_value` reset to 0.
- **Ignored start / reset:** `start` pulsed during GATE → no effect on sequence or timing. `rst` asserted during EMIT → all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/ring_osc_pkg.sv
// Shared definitions for the ring-oscillator scan sequencer.
package ring_osc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_GATE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_EMIT,
        ST_DONE
    } state_t;

    // The timer holds a reload value of (window - 1), so clog2 of the longest
    // window is enough; the result is clamped to one bit.
    function automatic int timer_width(input int gate_cycles, input int settle_cycles);
        int longest;
        longest = (gate_cycles > settle_cycles) ? gate_cycles : settle_cycles;
        return (longest < 2) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/ring_osc_timer.sv
// Loadable down-counter that times the gate and settle windows.
// When loaded with N-1, expired is high N cycles later and stays high.
module ring_osc_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         expired
);

    logic [W-1:0] count;

    // Count down to zero, then park there until the next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/ring_osc_scan_ctrl.sv
// Measurement sequencer: walks every oscillator through clear, gate, settle
// and capture, streams each count out and tracks the fastest oscillator.
module ring_osc_scan_ctrl
    import ring_osc_pkg::*;
#(
    parameter int NUM_RO        = 8,
    parameter int GATE_CYCLES   = 100,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8,
    parameter int SEL_W         = $clog2(NUM_RO)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [SEL_W-1:0] ro_sel,
    output logic             ro_en,
    output logic             cnt_clr,
    input  logic [CNT_W-1:0] cnt_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [SEL_W-1:0] res_idx,
    output logic [CNT_W-1:0] res_value,
    output logic [SEL_W-1:0] max_idx,
    output logic [CNT_W-1:0] max_value
);

    localparam int               TMR_W       = timer_width(GATE_CYCLES, SETTLE_CYCLES);
    localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_IDX    = SEL_W'(NUM_RO - 1);

    state_t           state;
    state_t           state_next;
    logic [SEL_W-1:0] idx;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_value;
    logic             tmr_expired;
    logic             scan_start;
    logic             handshake;

    assign scan_start = (state == ST_IDLE) && start && !abort;
    assign handshake  = (state == ST_EMIT) && res_ready && !abort;

    ring_osc_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_value),
        .expired    (tmr_expired)
    );

    // Next-state logic; the timer is reloaded on entry to each timed window
    // and abort overrides whatever transition was chosen.
    always_comb begin
        state_next = state;
        tmr_load   = 1'b0;
        tmr_value  = GATE_LOAD;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_next = ST_GATE;
                tmr_load   = 1'b1;
                tmr_value  = GATE_LOAD;
            end
            ST_GATE: begin
                if (tmr_expired) begin
                    state_next = ST_SETTLE;
                    tmr_load   = 1'b1;
                    tmr_value  = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                if (tmr_expired) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_next = ST_EMIT;
            end
            ST_EMIT: begin
                if (res_ready) begin
                    state_next = (idx == LAST_IDX) ? ST_DONE : ST_CLEAR;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_next = ST_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Control outputs decoded from the next state so they are flops that line
    // up exactly with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt_clr   <= 1'b0;
            ro_en     <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            busy      <= (state_next != ST_IDLE);
            done      <= (state_next == ST_DONE);
            cnt_clr   <= (state_next == ST_CLEAR);
            ro_en     <= (state_next == ST_GATE);
            res_valid <= (state_next == ST_EMIT);
        end
    end

    // Oscillator index; it only advances on an accepted result so ro_sel is
    // stable from CLEAR through EMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (scan_start) begin
            idx <= '0;
        end else if (handshake && (idx != LAST_IDX)) begin
            idx <= idx + SEL_W'(1);
        end
    end

    assign ro_sel = idx;

    // Result payload and running maximum; strict compare keeps the lower
    // index on ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_idx   <= '0;
            res_value <= '0;
            max_idx   <= '0;
            max_value <= '0;
        end else if (scan_start) begin
            max_idx   <= '0;
            max_value <= '0;
        end else if ((state == ST_CAPTURE) && !abort) begin
            res_idx   <= idx;
            res_value <= cnt_in;
            if (cnt_in > max_value) begin
                max_idx   <= idx;
                max_value <= cnt_in;
            end
        end
    end

endmodule

// File: tb/tb_ring_osc_scan_ctrl.sv
// Directed testbench for ring_osc_scan_ctrl with a result scoreboard.
module tb_ring_osc_scan_ctrl;

    localparam int NUM_RO        = 4;
    localparam int GATE_CYCLES   = 10;
    localparam int SETTLE_CYCLES = 2;
    localparam int CNT_W         = 8;
    localparam int SEL_W         = 2;
    localparam int SLOT          = GATE_CYCLES + SETTLE_CYCLES + 3;
    localparam int DONE_CYCLE    = NUM_RO * SLOT + 1;

    typedef struct {
        logic [SEL_W-1:0] idx;
        logic [CNT_W-1:0] value;
    } result_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             res_ready = 1'b1;
    logic             busy, done, ro_en, cnt_clr, res_valid;
    logic [SEL_W-1:0] ro_sel, res_idx, max_idx;
    logic [CNT_W-1:0] cnt_in, res_value, max_value;
    logic [CNT_W-1:0] cnt_tab [NUM_RO];

    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    int      start_cyc = 0;
    result_t exp_q[$];
    int      en_count [NUM_RO];
    int      clr_count, hs_count, done_count, last_hs_rel, done_cyc;
    bit      done_seen, prev_clr, prev_hs;

    // The ring counter model returns a fixed count per selected oscillator.
    assign cnt_in = cnt_tab[ro_sel];

    ring_osc_scan_ctrl #(
        .NUM_RO        (NUM_RO),
        .GATE_CYCLES   (GATE_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .ro_sel    (ro_sel),
        .ro_en     (ro_en),
        .cnt_clr   (cnt_clr),
        .cnt_in    (cnt_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_idx   (res_idx),
        .res_value (res_value),
        .max_idx   (max_idx),
        .max_value (max_value)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter; cycle numbers are relative to start_cyc.
    always @(posedge clk) cyc <= cyc + 1;

    // Safety net so the bench always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Launch a scan: load the count table, queue expected results, pulse start
    // in relative cycle 0 and return at cycle 1.
    task automatic applyStimulus(input logic [CNT_W-1:0] v0, input logic [CNT_W-1:0] v1,
                                 input logic [CNT_W-1:0] v2, input logic [CNT_W-1:0] v3);
        result_t r;
        cnt_tab[0] = v0;
        cnt_tab[1] = v1;
        cnt_tab[2] = v2;
        cnt_tab[3] = v3;
        exp_q.delete();
        for (int i = 0; i < NUM_RO; i++) begin
            en_count[i] = 0;
            r.idx   = SEL_W'(i);
            r.value = cnt_tab[i];
            exp_q.push_back(r);
        end
        clr_count = 0;
        hs_count  = 0;
        done_seen = 0;
        prev_clr  = 0;
        prev_hs   = 0;
        start_cyc = cyc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitCycle(input int rel);
        while (cyc - start_cyc < rel) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait (bounded) for done, then check its cycle, busy and the maximum.
    task automatic waitDone(input int exp_cycle, input int bound);
        int n;
        logic [SEL_W-1:0] m_idx;
        logic [CNT_W-1:0] m_val;
        n = 0;
        while (!done_seen && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        m_idx = '0;
        m_val = '0;
        for (int i = 0; i < NUM_RO; i++) begin
            if (cnt_tab[i] > m_val) begin
                m_val = cnt_tab[i];
                m_idx = SEL_W'(i);
            end
        end
        checkOutput("done_seen", 32'(done_seen), 1);
        checkOutput("done_cycle", done_cyc, exp_cycle);
        checkOutput("busy_after_done", 32'(busy), 0);
        checkOutput("max_idx", 32'(max_idx), 32'(m_idx));
        checkOutput("max_value", 32'(max_value), 32'(m_val));
        checkOutput("queue_drained", exp_q.size(), 0);
        checkOutput("handshakes", hs_count, NUM_RO);
        checkOutput("clr_pulses", clr_count, NUM_RO);
        for (int i = 0; i < NUM_RO; i++) begin
            checkOutput($sformatf("ro_en_cycles_%0d", i), en_count[i], GATE_CYCLES);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_ro_sel"}, 32'(ro_sel), 0);
        checkOutput({tag, "_ro_en"}, 32'(ro_en), 0);
        checkOutput({tag, "_cnt_clr"}, 32'(cnt_clr), 0);
        checkOutput({tag, "_res_valid"}, 32'(res_valid), 0);
        checkOutput({tag, "_res_idx"}, 32'(res_idx), 0);
        checkOutput({tag, "_res_value"}, 32'(res_value), 0);
        checkOutput({tag, "_max_idx"}, 32'(max_idx), 0);
        checkOutput({tag, "_max_value"}, 32'(max_value), 0);
    endtask

    // Monitor: scoreboard pops on handshake, window/clear bookkeeping, done capture.
    always @(negedge clk) begin
        int rel;
        if (!rst) begin
            rel = cyc - start_cyc;
            if (done) begin
                done_seen = 1;
                done_cyc  = rel;
                done_count++;
            end
            if (ro_en) en_count[ro_sel]++;
            if (prev_clr) checkOutput("clr_width", 32'(cnt_clr), 0);
            if (cnt_clr) begin
                checkOutput("clr_sel", 32'(ro_sel), clr_count);
                clr_count++;
            end
            prev_clr = cnt_clr;
            if (prev_hs) checkOutput("valid_len", 32'(res_valid), 0);
            prev_hs = 0;
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("valid_unexpected", 32'(res_valid), 0);
                end else begin
                    checkOutput("res_idx", 32'(res_idx), 32'(exp_q[0].idx));
                    checkOutput("res_value", 32'(res_value), 32'(exp_q[0].value));
                    checkOutput("ro_en_in_emit", 32'(ro_en), 0);
                    checkOutput("ro_sel_in_emit", 32'(ro_sel), 32'(exp_q[0].idx));
                    if (res_ready) begin
                        void'(exp_q.pop_front());
                        prev_hs = 1;
                        hs_count++;
                        last_hs_rel = rel;
                    end
                end
            end
        end
    end

    // Directed sequence of scenarios.
    initial begin
        int saved_hs;
        int saved_done;
        for (int i = 0; i < NUM_RO; i++) cnt_tab[i] = '0;
        done_count = 0;
        clr_count  = 0;
        hs_count   = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // start and abort together in IDLE stay in IDLE.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start_abort_busy", 32'(busy), 0);
        checkOutput("start_abort_clr", 32'(cnt_clr), 0);

        // Nominal scan with a tie on the maximum.
        $display("[TB] nominal scan");
        applyStimulus(8'd40, 8'd55, 8'd30, 8'd55);
        checkOutput("first_clr", 32'(cnt_clr), 1);
        checkOutput("first_busy", 32'(busy), 1);
        waitDone(DONE_CYCLE, 200);

        // Backpressure on idx 2 for five cycles.
        $display("[TB] backpressure scan");
        applyStimulus(8'd10, 8'd20, 8'd90, 8'd5);
        waitCycle(3 * SLOT);
        checkOutput("bp_valid", 32'(res_valid), 1);
        checkOutput("bp_idx", 32'(res_idx), 2);
        res_ready = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        checkOutput("bp_still_valid", 32'(res_valid), 1);
        checkOutput("bp_ro_en", 32'(ro_en), 0);
        res_ready = 1'b1;
        waitDone(DONE_CYCLE + 5, 200);

        // Abort in the gate window of idx 1, then rescan.
        $display("[TB] abort scan");
        applyStimulus(8'd70, 8'd60, 8'd50, 8'd40);
        waitCycle(20);
        checkOutput("abort_pre_ro_en", 32'(ro_en), 1);
        checkOutput("abort_pre_sel", 32'(ro_sel), 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abort_ro_en", 32'(ro_en), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_valid", 32'(res_valid), 0);
        checkOutput("abort_clr", 32'(cnt_clr), 0);
        exp_q.delete();
        saved_hs   = hs_count;
        saved_done = done_count;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("abort_no_results", hs_count, saved_hs);
        checkOutput("abort_no_done", done_count, saved_done);
        checkOutput("abort_partial_max", 32'(max_value), 70);
        applyStimulus(8'd3, 8'd9, 8'd9, 8'd1);
        checkOutput("rescan_max_cleared", 32'(max_value), 0);
        checkOutput("rescan_sel", 32'(ro_sel), 0);
        checkOutput("rescan_clr", 32'(cnt_clr), 1);
        waitDone(DONE_CYCLE, 200);

        // start during GATE is ignored; reset during EMIT clears everything.
        $display("[TB] ignored start and reset");
        applyStimulus(8'd7, 8'd8, 8'd9, 8'd10);
        waitCycle(5);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("ign_ro_en", 32'(ro_en), 1);
        checkOutput("ign_sel", 32'(ro_sel), 0);
        waitCycle(2 * SLOT);
        checkOutput("ign_hs_cycle", last_hs_rel, SLOT);
        checkOutput("ign_clr_count", clr_count, 2);
        checkOutput("ign_valid", 32'(res_valid), 1);
        checkOutput("ign_idx", 32'(res_idx), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkResetState("emit_reset");
        rst = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("post_reset_busy", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
